// File: rtl/el2_dccm_mem_pkg.sv
// Shared definitions for the DCCM bank array: clear-pass ECC value,
// init sequencer states and the stored bank word layout.
package el2_dccm_mem_pkg;

    // SECDED check bits of an all-zero data word
    localparam logic [6:0] ZERO_ECC = 7'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } init_state_e;

    typedef struct packed {
        logic [6:0]  ecc;
        logic [31:0] data;
    } dccm_word_t;

endpackage

// File: rtl/el2_dccm_bank_ram.sv
// Single DCCM bank: synchronous RAM, one read or one write per cycle,
// registered read port that holds its value when the bank is not read.
// i_rd_flip is XORed into the {ecc,data} word captured on a read.
module el2_dccm_bank_ram
    import el2_dccm_mem_pkg::*;
#(
    parameter int unsigned IDX = 11,
    parameter int unsigned DW  = 32,
    parameter int unsigned EW  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [IDX-1:0]    i_addr,
    input  logic [DW-1:0]     i_wdata,
    input  logic [EW-1:0]     i_wecc,
    input  logic [DW+EW-1:0]  i_rd_flip,
    output logic [DW-1:0]     o_dout,
    output logic [EW-1:0]     o_ecc
);

    localparam int unsigned DEPTH = 1 << IDX;

    logic [DW+EW-1:0] r_mem [DEPTH];
    logic [DW-1:0]    r_dout;
    logic [EW-1:0]    r_ecc;
    logic [DW+EW-1:0] w_rd_word;

    assign w_rd_word = r_mem[i_addr] ^ i_rd_flip;

    // Array write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            r_mem[i_addr] <= {i_wecc, i_wdata};
        end
    end

    // Registered read port, held on writes and idle cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
            r_ecc  <= '0;
        end else if (i_en && !i_we) begin
            {r_ecc, r_dout} <= w_rd_word;
        end
    end

    assign o_dout = r_dout;
    assign o_ecc  = r_ecc;

endmodule

// File: rtl/el2_dccm_bank_array.sv
// DCCM bank array behind the mem-export interface: NB independent banks
// plus a zero-initialisation sequencer that writes data 0 / ZERO_ECC to
// every index of every bank. Core accesses are blocked while clearing.
// Optional macro DCCM_ERR_INJ_EN adds a one-shot read-path bit flip.
module el2_dccm_bank_array
    import el2_dccm_mem_pkg::*;
#(
    parameter int unsigned DCCM_NUM_BANKS  = 8,
    parameter int unsigned DCCM_INDEX_BITS = 11,
    parameter int unsigned DCCM_DATA_WIDTH = 32,
    parameter int unsigned DCCM_ECC_WIDTH  = 7,
    parameter int unsigned AUTO_INIT       = 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [DCCM_NUM_BANKS-1:0]                   dccm_clken,
    input  logic [DCCM_NUM_BANKS-1:0]                   dccm_wren_bank,
    input  logic [DCCM_NUM_BANKS*DCCM_INDEX_BITS-1:0]   dccm_addr_bank,
    input  logic [DCCM_NUM_BANKS*DCCM_DATA_WIDTH-1:0]   dccm_wr_data_bank,
    input  logic [DCCM_NUM_BANKS*DCCM_ECC_WIDTH-1:0]    dccm_wr_ecc_bank,
    input  logic                                        init_start,
`ifdef DCCM_ERR_INJ_EN
    input  logic                                        err_inj_arm,
    input  logic [$clog2(DCCM_NUM_BANKS)-1:0]           err_inj_bank,
    input  logic [$clog2(DCCM_DATA_WIDTH+DCCM_ECC_WIDTH)-1:0] err_inj_bit,
`endif
    output logic [DCCM_NUM_BANKS*DCCM_DATA_WIDTH-1:0]   dccm_bank_dout,
    output logic [DCCM_NUM_BANKS*DCCM_ECC_WIDTH-1:0]    dccm_bank_ecc,
    output logic                                        init_busy,
    output logic                                        init_done
);

    localparam int unsigned NB  = DCCM_NUM_BANKS;
    localparam int unsigned IDX = DCCM_INDEX_BITS;
    localparam int unsigned DW  = DCCM_DATA_WIDTH;
    localparam int unsigned EW  = DCCM_ECC_WIDTH;
    localparam int unsigned WW  = DW + EW;

    localparam logic [IDX-1:0] CNT_LAST = '1;
    localparam logic [EW-1:0]  ECC_CLR  = EW'(ZERO_ECC);

    init_state_e     r_state;
    logic [IDX-1:0]  r_cnt;
    logic            r_auto;
    logic            w_busy;
    logic [WW-1:0]   w_flip [NB];

    assign w_busy    = (r_state == CLEAR);
    assign init_busy = w_busy;
    assign init_done = (r_state == DONE);

    // Init sequencer; r_auto marks the first cycle after reset release
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_auto  <= (AUTO_INIT != 0);
        end else begin
            r_auto <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (init_start || r_auto) begin
                        r_state <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + IDX'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef DCCM_ERR_INJ_EN
    localparam int unsigned BW   = $clog2(NB);
    localparam int unsigned BITW = $clog2(WW);

    logic            r_inj_pend;
    logic [BW-1:0]   r_inj_bank;
    logic [BITW-1:0] r_inj_bit;
    logic [NB-1:0]   w_rd;
    logic            w_inj_hit;

    assign w_rd      = dccm_clken & ~dccm_wren_bank & {NB{~w_busy}};
    assign w_inj_hit = r_inj_pend && w_rd[r_inj_bank];

    // One-shot injection request; a new arm replaces any pending one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inj_pend <= 1'b0;
            r_inj_bank <= '0;
            r_inj_bit  <= '0;
        end else if (err_inj_arm) begin
            r_inj_pend <= 1'b1;
            r_inj_bank <= err_inj_bank;
            r_inj_bit  <= err_inj_bit;
        end else if (w_inj_hit) begin
            r_inj_pend <= 1'b0;
        end
    end
`endif

    for (genvar g = 0; g < NB; g++) begin : g_bank
        logic           w_en;
        logic           w_we;
        logic [IDX-1:0] w_addr;
        logic [DW-1:0]  w_wdata;
        logic [EW-1:0]  w_wecc;

        // Clear pass owns every bank's write port while busy
        assign w_en    = w_busy | dccm_clken[g];
        assign w_we    = w_busy | dccm_wren_bank[g];
        assign w_addr  = w_busy ? r_cnt   : dccm_addr_bank[g*IDX +: IDX];
        assign w_wdata = w_busy ? '0      : dccm_wr_data_bank[g*DW +: DW];
        assign w_wecc  = w_busy ? ECC_CLR : dccm_wr_ecc_bank[g*EW +: EW];

`ifdef DCCM_ERR_INJ_EN
        assign w_flip[g] = (w_inj_hit && (r_inj_bank == BW'(g))) ? (WW'(1) << r_inj_bit) : '0;
`else
        assign w_flip[g] = '0;
`endif

        el2_dccm_bank_ram #(
            .IDX (IDX),
            .DW  (DW),
            .EW  (EW)
        ) u_ram (
            .clk       (clk),
            .rst       (rst),
            .i_en      (w_en),
            .i_we      (w_we),
            .i_addr    (w_addr),
            .i_wdata   (w_wdata),
            .i_wecc    (w_wecc),
            .i_rd_flip (w_flip[g]),
            .o_dout    (dccm_bank_dout[g*DW +: DW]),
            .o_ecc     (dccm_bank_ecc[g*EW +: EW])
        );
    end

endmodule

// File: tb/tb_el2_dccm_bank_array.sv
module tb_el2_dccm_bank_array;

    localparam int NB    = 8;
    localparam int IDX   = 11;
    localparam int DW    = 32;
    localparam int EW    = 7;
    localparam int DEPTH = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_a, rst_b, start_a, start_b;
    logic [NB-1:0]      clken, wren;
    logic [NB*IDX-1:0]  addr;
    logic [NB*DW-1:0]   wdata;
    logic [NB*EW-1:0]   wecc;
    logic [NB*DW-1:0]   dout_a, dout_b;
    logic [NB*EW-1:0]   ecc_a, ecc_b;
    logic               busy_a, busy_b, done_a, done_b;
`ifdef DCCM_ERR_INJ_EN
    logic               arm;
    logic [2:0]         inj_bank;
    logic [5:0]         inj_bit;
`endif

    int total = 0;
    int bad   = 0;

    el2_dccm_bank_array dut (
        .clk               (clk),
        .rst               (rst_a),
        .dccm_clken        (clken),
        .dccm_wren_bank    (wren),
        .dccm_addr_bank    (addr),
        .dccm_wr_data_bank (wdata),
        .dccm_wr_ecc_bank  (wecc),
        .init_start        (start_a),
`ifdef DCCM_ERR_INJ_EN
        .err_inj_arm       (arm),
        .err_inj_bank      (inj_bank),
        .err_inj_bit       (inj_bit),
`endif
        .dccm_bank_dout    (dout_a),
        .dccm_bank_ecc     (ecc_a),
        .init_busy         (busy_a),
        .init_done         (done_a)
    );

    el2_dccm_bank_array #(.AUTO_INIT(0)) dut_b (
        .clk               (clk),
        .rst               (rst_b),
        .dccm_clken        (clken),
        .dccm_wren_bank    (wren),
        .dccm_addr_bank    (addr),
        .dccm_wr_data_bank (wdata),
        .dccm_wr_ecc_bank  (wecc),
        .init_start        (start_b),
`ifdef DCCM_ERR_INJ_EN
        .err_inj_arm       (arm),
        .err_inj_bank      (inj_bank),
        .err_inj_bit       (inj_bit),
`endif
        .dccm_bank_dout    (dout_b),
        .dccm_bank_ecc     (ecc_b),
        .init_busy         (busy_b),
        .init_done         (done_b)
    );

    task tick;
        @(posedge clk);
        #1;
    endtask

    task idle_bus;
        clken = '0;
        wren  = '0;
    endtask

    task automatic put(input int b, input logic we, input logic [IDX-1:0] idx,
                       input logic [DW-1:0] d, input logic [EW-1:0] e);
        clken[b]            = 1'b1;
        wren[b]             = we;
        addr[b*IDX +: IDX]  = idx;
        wdata[b*DW +: DW]   = d;
        wecc[b*EW +: EW]    = e;
    endtask

    function automatic logic [DW-1:0] da(input int b);
        return dout_a[b*DW +: DW];
    endfunction
    function automatic logic [EW-1:0] ea(input int b);
        return ecc_a[b*EW +: EW];
    endfunction
    function automatic logic [DW-1:0] db(input int b);
        return dout_b[b*DW +: DW];
    endfunction
    function automatic logic [EW-1:0] eb(input int b);
        return ecc_b[b*EW +: EW];
    endfunction

    task test_reset;
        total++;
        if (dout_a !== '0 || ecc_a !== '0) begin
            $display("FAIL reset_out_a got dout=%h ecc=%h exp 0", dout_a, ecc_a); bad++;
        end
        total++;
        if ({busy_a, done_a} !== 2'b00) begin
            $display("FAIL reset_flags_a got busy=%b done=%b exp 0 0", busy_a, done_a); bad++;
        end
        total++;
        if (dout_b !== '0 || ecc_b !== '0 || {busy_b, done_b} !== 2'b00) begin
            $display("FAIL reset_b got dout=%h busy=%b done=%b exp 0", dout_b, busy_b, done_b); bad++;
        end
        // array is not reset: preload idx 0x7FF so the clear pass has work to do
        for (int b = 0; b < NB; b++) put(b, 1'b1, 11'h7FF, 32'hFFFF_FFFF, 7'h7F);
        tick;
        idle_bus;
    endtask

    task test_auto_init;
        int nbusy, ndone, last_busy, done_at, nbusy_b;
        nbusy = 0; ndone = 0; last_busy = -1; done_at = -1; nbusy_b = 0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        total++;
        if (busy_a !== 1'b0) begin
            $display("FAIL auto_busy_before got %b exp 0", busy_a); bad++;
        end
        for (int c = 0; c < DEPTH + 50; c++) begin
            tick;
            if (busy_a) begin nbusy++; last_busy = c; end
            if (done_a) begin ndone++; done_at = c; end
            if (busy_b) nbusy_b++;
        end
        total++;
        if (nbusy != DEPTH) begin
            $display("FAIL auto_busy_cycles got %0d exp %0d", nbusy, DEPTH); bad++;
        end
        total++;
        if (ndone != 1 || done_at != last_busy + 1) begin
            $display("FAIL auto_done_pulse got count=%0d at=%0d exp 1 at %0d", ndone, done_at, last_busy + 1); bad++;
        end
        total++;
        if (nbusy_b != 0) begin
            $display("FAIL noauto_busy got %0d exp 0", nbusy_b); bad++;
        end
        for (int b = 0; b < NB; b++) put(b, 1'b1, 11'd5, 32'h1000_0000 + b, 7'(b + 1));
        tick;
        for (int b = 0; b < NB; b++) put(b, 1'b0, 11'd5, '0, '0);
        tick;
        idle_bus;
        for (int b = 0; b < NB; b++) begin
            total++;
            if (da(b) !== 32'h1000_0000 + b || ea(b) !== 7'(b + 1)) begin
                $display("FAIL idx5_bank%0d got %h/%h exp %h/%h", b, da(b), ea(b), 32'h1000_0000 + b, 7'(b + 1)); bad++;
            end
        end
        for (int b = 0; b < NB; b++) put(b, 1'b0, 11'h7FF, '0, '0);
        tick;
        idle_bus;
        for (int b = 0; b < NB; b++) begin
            total++;
            if (da(b) !== 32'h0 || ea(b) !== 7'h00) begin
                $display("FAIL cleared_7ff_bank%0d got %h/%h exp 0/00", b, da(b), ea(b)); bad++;
            end
        end
    endtask

    task test_write_read;
        put(3, 1'b1, 11'h010, 32'hDEAD_BEEF, 7'h5A);
        tick;
        idle_bus;
        total++;
        if (da(3) !== 32'h0) begin
            $display("FAIL wr_hold_b3 got %h exp 0", da(3)); bad++;
        end
        put(3, 1'b0, 11'h010, '0, '0);
        put(4, 1'b1, 11'h010, 32'h1234_5678, 7'h11);
        tick;
        idle_bus;
        total++;
        if (da(3) !== 32'hDEAD_BEEF || ea(3) !== 7'h5A) begin
            $display("FAIL rd_b3 got %h/%h exp deadbeef/5a", da(3), ea(3)); bad++;
        end
        total++;
        if (da(4) !== 32'h0) begin
            $display("FAIL wr_hold_b4 got %h exp 0", da(4)); bad++;
        end
        put(4, 1'b0, 11'h010, '0, '0);
        tick;
        idle_bus;
        total++;
        if (da(4) !== 32'h1234_5678 || ea(4) !== 7'h11 || da(3) !== 32'hDEAD_BEEF) begin
            $display("FAIL rd_b4 got %h/%h b3=%h exp 12345678/11 b3=deadbeef", da(4), ea(4), da(3)); bad++;
        end
    endtask

    task test_hold;
        put(0, 1'b0, 11'd5, '0, '0);
        tick;
        idle_bus;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (da(0) !== 32'h1000_0000 || ea(0) !== 7'h01) begin
                $display("FAIL hold_idle%0d got %h/%h exp 10000000/01", c, da(0), ea(0)); bad++;
            end
            tick;
        end
        put(0, 1'b1, 11'd5, 32'h1111_1111, 7'h22);
        tick;
        idle_bus;
        total++;
        if (da(0) !== 32'h1000_0000) begin
            $display("FAIL hold_on_write got %h exp 10000000", da(0)); bad++;
        end
        wren[0] = 1'b1;
        wdata[0 +: DW] = 32'h2222_2222;
        tick;
        idle_bus;
        put(0, 1'b0, 11'd5, '0, '0);
        tick;
        idle_bus;
        total++;
        if (da(0) !== 32'h1111_1111 || ea(0) !== 7'h22) begin
            $display("FAIL wren_gated got %h/%h exp 11111111/22", da(0), ea(0)); bad++;
        end
    endtask

    task test_restart_ignored;
        int nbusy, ndone;
        nbusy = 0; ndone = 0;
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        for (int c = 0; c < DEPTH + 50; c++) begin
            if (busy_a) nbusy++;
            if (done_a) ndone++;
            start_a = (c == 10 || c == 500 || done_a);
            tick;
        end
        start_a = 1'b0;
        total++;
        if (nbusy != DEPTH || ndone != 1) begin
            $display("FAIL restart_ignored got busy=%0d done=%0d exp %0d 1", nbusy, ndone, DEPTH); bad++;
        end
        put(3, 1'b0, 11'h010, '0, '0);
        tick;
        idle_bus;
        total++;
        if (da(3) !== 32'h0 || ea(3) !== 7'h00) begin
            $display("FAIL restart_cleared got %h/%h exp 0/00", da(3), ea(3)); bad++;
        end
    endtask

    task test_reset_mid_clear;
        int nbusy, ndone, nbusy_post;
        nbusy = 0; ndone = 0; nbusy_post = 0;
        put(1, 1'b1, 11'h7F0, 32'hCAFE_F00D, 7'h33);
        tick;
        put(1, 1'b1, 11'd50, 32'h5555_AAAA, 7'h2A);
        tick;
        idle_bus;
        start_b = 1'b1;
        tick;
        start_b = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (c == 20) put(1, 1'b1, 11'h7F0, 32'hBAD0_BAD0, 7'h44);
            else idle_bus;
            tick;
        end
        idle_bus;
        total++;
        if (busy_b !== 1'b1) begin
            $display("FAIL midclr_busy got %b exp 1", busy_b); bad++;
        end
        rst_b = 1'b1;
        tick;
        total++;
        if (busy_b !== 1'b0 || done_b !== 1'b0) begin
            $display("FAIL midclr_abort got busy=%b done=%b exp 0 0", busy_b, done_b); bad++;
        end
        rst_b = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick;
            if (busy_b) nbusy_post++;
        end
        total++;
        if (nbusy_post != 0) begin
            $display("FAIL midclr_no_restart got %0d exp 0", nbusy_post); bad++;
        end
        put(1, 1'b0, 11'h7F0, '0, '0);
        tick;
        idle_bus;
        total++;
        if (db(1) !== 32'hCAFE_F00D || eb(1) !== 7'h33) begin
            $display("FAIL midclr_untouched got %h/%h exp cafef00d/33", db(1), eb(1)); bad++;
        end
        put(1, 1'b0, 11'd50, '0, '0);
        tick;
        idle_bus;
        total++;
        if (db(1) !== 32'h0 || eb(1) !== 7'h00) begin
            $display("FAIL midclr_cleared got %h/%h exp 0/00", db(1), eb(1)); bad++;
        end
        start_b = 1'b1;
        tick;
        start_b = 1'b0;
        for (int c = 0; c < DEPTH + 50; c++) begin
            if (busy_b) nbusy++;
            if (done_b) ndone++;
            tick;
        end
        total++;
        if (nbusy != DEPTH || ndone != 1) begin
            $display("FAIL midclr_full_pass got busy=%0d done=%0d exp %0d 1", nbusy, ndone, DEPTH); bad++;
        end
        put(1, 1'b0, 11'h7F0, '0, '0);
        tick;
        idle_bus;
        total++;
        if (db(1) !== 32'h0 || eb(1) !== 7'h00) begin
            $display("FAIL midclr_7f0_after got %h/%h exp 0/00", db(1), eb(1)); bad++;
        end
    endtask

`ifdef DCCM_ERR_INJ_EN
    task test_err_inj;
        put(2, 1'b1, 11'd1, 32'h1, 7'h00);
        tick;
        idle_bus;
        arm = 1'b1; inj_bank = 3'd2; inj_bit = 6'd0;
        tick;
        arm = 1'b0;
        for (int r = 0; r < 2; r++) begin
            put(2, 1'b0, 11'd1, '0, '0);
            tick;
            idle_bus;
            total++;
            if (da(2) !== ((r == 0) ? 32'h0 : 32'h1) || ea(2) !== 7'h00) begin
                $display("FAIL inj_bit0_rd%0d got %h/%h exp %h/00", r, da(2), ea(2), (r == 0) ? 32'h0 : 32'h1); bad++;
            end
        end
        arm = 1'b1; inj_bank = 3'd2; inj_bit = 6'd0;
        tick;
        inj_bit = 6'd32;
        tick;
        arm = 1'b0;
        put(2, 1'b0, 11'd1, '0, '0);
        tick;
        idle_bus;
        total++;
        if (da(2) !== 32'h1 || ea(2) !== 7'h01) begin
            $display("FAIL inj_rearm_ecc got %h/%h exp 00000001/01", da(2), ea(2)); bad++;
        end
    endtask
`endif

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        clken = '0; wren = '0; addr = '0; wdata = '0; wecc = '0;
`ifdef DCCM_ERR_INJ_EN
        arm = 1'b0; inj_bank = '0; inj_bit = '0;
`endif
        tick; tick; tick;
        test_reset;
        test_auto_init;
        test_write_read;
        test_hold;
        test_restart_ignored;
        test_reset_mid_clear;
`ifdef DCCM_ERR_INJ_EN
        test_err_inj;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
